// File: rtl/gpu_host_bridge_if.sv
// Host-side and bus-side signals of the GPU host bridge.
// The slave modport is the bridge's view; the master modport is the host/bus agent's view.
interface gpu_host_bridge_if;
  logic        host_req;
  logic        host_wr;
  logic [13:0] host_addr;
  logic [15:0] host_din;
  logic [15:0] host_dout;
  logic        host_ack;
  logic        host_err;
  logic        ioserv;
  logic [31:0] mem_data;
  logic        ioreq;
  logic        iowr;
  logic [12:0] cpuaddr;
  logic [31:0] cpudata;

  modport slave (
    input  host_req, host_wr, host_addr, host_din, ioserv, mem_data,
    output host_dout, host_ack, host_err, ioreq, iowr, cpuaddr, cpudata
  );

  modport master (
    output host_req, host_wr, host_addr, host_din, ioserv, mem_data,
    input  host_dout, host_ack, host_err, ioreq, iowr, cpuaddr, cpudata
  );
endinterface

// File: rtl/gpu_host_bridge.sv
// Bridges 16-bit host halfword accesses onto the 32-bit GPU I/O bus, advancing only on tick.
// Optional read-halfword latch is enabled by defining GPU_HOST_RDLATCH_EN.
//
// Handshakes: the host side is four-phase (host_req rises, bridge raises host_ack,
// host drops host_req, bridge drops host_ack); the bus side raises ioreq for exactly
// one tick and then waits for the ioserv grant, with iowr/cpuaddr/cpudata held stable.
module gpu_host_bridge (
  input  logic                     sys_clk,
  input  logic                     resetl,
  input  logic                     tick,
  input  logic                     big_io,
  gpu_host_bridge_if.slave         bus,
  output logic [2:0]               dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_SERV  = 3'd2,
    S_CAPT  = 3'd3,
    S_ACK   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        ioreq_q, ioreq_d;
  logic        iowr_q, iowr_d;
  logic [12:0] cpuaddr_q, cpuaddr_d;
  logic [31:0] cpudata_q, cpudata_d;
  logic [15:0] host_dout_q, host_dout_d;
  logic        host_ack_q, host_ack_d;
  logic        host_err_q, host_err_d;
  logic        wpend_q, wpend_d;
  logic [15:0] wbuf_q, wbuf_d;
  logic [3:0]  tmo_q, tmo_d;
  logic        big_q, big_d;
  logic        alo_q, alo_d;
  logic [15:0] wbuf_eff;
  logic        hit;

`ifdef GPU_HOST_RDLATCH_EN
  logic        rvalid_q, rvalid_d;
  logic [12:0] raddr_q, raddr_d;
  logic [31:0] rbuf_q, rbuf_d;
  assign hit = !bus.host_wr && bus.host_addr[0] && rvalid_q &&
               (bus.host_addr[13:1] == raddr_q);
`else
  logic        rvalid_q;
  assign rvalid_q = 1'b0;
  assign hit      = rvalid_q;
`endif

  // A second-half write with nothing pending merges against zero.
  assign wbuf_eff = wpend_q ? wbuf_q : 16'h0000;

  always_ff @(posedge sys_clk) begin
    if (!resetl) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (tick) begin
      case (state_q)
        S_IDLE: begin
          if (bus.host_req) begin
            if ((bus.host_wr && !bus.host_addr[0]) || hit) state_d = S_ACK;
            else                                          state_d = S_ISSUE;
          end
        end
        S_ISSUE: state_d = S_SERV;
        S_SERV: begin
          if (bus.ioserv)          state_d = iowr_q ? S_ACK : S_CAPT;
          else if (tmo_q == 4'd14) state_d = S_ACK;
        end
        S_CAPT:  state_d = S_ACK;
        S_ACK:   if (!bus.host_req) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    ioreq_d     = ioreq_q;
    iowr_d      = iowr_q;
    cpuaddr_d   = cpuaddr_q;
    cpudata_d   = cpudata_q;
    host_dout_d = host_dout_q;
    host_ack_d  = host_ack_q;
    host_err_d  = host_err_q;
    wpend_d     = wpend_q;
    wbuf_d      = wbuf_q;
    tmo_d       = tmo_q;
    big_d       = big_q;
    alo_d       = alo_q;
`ifdef GPU_HOST_RDLATCH_EN
    rvalid_d    = rvalid_q;
    raddr_d     = raddr_q;
    rbuf_d      = rbuf_q;
`endif
    if (tick) begin
      case (state_q)
        S_IDLE: begin
          if (bus.host_req) begin
            big_d = big_io;
            alo_d = bus.host_addr[0];
            if (bus.host_wr) begin
`ifdef GPU_HOST_RDLATCH_EN
              if (bus.host_addr[13:1] == raddr_q) rvalid_d = 1'b0;
`endif
              if (!bus.host_addr[0]) begin
                wbuf_d     = bus.host_din;
                wpend_d    = 1'b1;
                host_ack_d = 1'b1;
              end else begin
                cpudata_d = big_io ? {wbuf_eff, bus.host_din} : {bus.host_din, wbuf_eff};
                cpuaddr_d = bus.host_addr[13:1];
                iowr_d    = 1'b1;
                ioreq_d   = 1'b1;
                wpend_d   = 1'b0;
              end
            end else if (hit) begin
`ifdef GPU_HOST_RDLATCH_EN
              // Second half of a latched long word: big_io picks which half is "other".
              host_dout_d = big_io ? rbuf_q[15:0] : rbuf_q[31:16];
`endif
              host_ack_d = 1'b1;
            end else begin
              cpuaddr_d = bus.host_addr[13:1];
              iowr_d    = 1'b0;
              ioreq_d   = 1'b1;
            end
          end
        end
        S_ISSUE: ioreq_d = 1'b0;
        S_SERV: begin
          if (bus.ioserv) begin
            tmo_d = 4'd0;
            if (iowr_q) host_ack_d = 1'b1;
          end else if (tmo_q == 4'd14) begin
            tmo_d       = 4'd0;
            host_err_d  = 1'b1;
            host_dout_d = 16'h0000;
            host_ack_d  = 1'b1;
`ifdef GPU_HOST_RDLATCH_EN
            rvalid_d    = 1'b0;
`endif
          end else begin
            tmo_d = tmo_q + 4'd1;
          end
        end
        S_CAPT: begin
          // Upper half is selected when big_io and addr[1] disagree.
          host_dout_d = (big_q ^ alo_q) ? bus.mem_data[31:16] : bus.mem_data[15:0];
          host_ack_d  = 1'b1;
`ifdef GPU_HOST_RDLATCH_EN
          rbuf_d = bus.mem_data;
          if (!alo_q) begin
            rvalid_d = 1'b1;
            raddr_d  = cpuaddr_q;
          end
`endif
        end
        S_ACK: begin
          if (!bus.host_req) begin
            host_ack_d = 1'b0;
            host_err_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!resetl) begin
      ioreq_q     <= 1'b0;
      iowr_q      <= 1'b0;
      cpuaddr_q   <= 13'd0;
      cpudata_q   <= 32'd0;
      host_dout_q <= 16'd0;
      host_ack_q  <= 1'b0;
      host_err_q  <= 1'b0;
      wpend_q     <= 1'b0;
      wbuf_q      <= 16'd0;
      tmo_q       <= 4'd0;
      big_q       <= 1'b0;
      alo_q       <= 1'b0;
`ifdef GPU_HOST_RDLATCH_EN
      rvalid_q    <= 1'b0;
      raddr_q     <= 13'd0;
      rbuf_q      <= 32'd0;
`endif
    end else begin
      ioreq_q     <= ioreq_d;
      iowr_q      <= iowr_d;
      cpuaddr_q   <= cpuaddr_d;
      cpudata_q   <= cpudata_d;
      host_dout_q <= host_dout_d;
      host_ack_q  <= host_ack_d;
      host_err_q  <= host_err_d;
      wpend_q     <= wpend_d;
      wbuf_q      <= wbuf_d;
      tmo_q       <= tmo_d;
      big_q       <= big_d;
      alo_q       <= alo_d;
`ifdef GPU_HOST_RDLATCH_EN
      rvalid_q    <= rvalid_d;
      raddr_q     <= raddr_d;
      rbuf_q      <= rbuf_d;
`endif
    end
  end

  assign bus.ioreq     = ioreq_q;
  assign bus.iowr      = iowr_q;
  assign bus.cpuaddr   = cpuaddr_q;
  assign bus.cpudata   = cpudata_q;
  assign bus.host_dout = host_dout_q;
  assign bus.host_ack  = host_ack_q;
  assign bus.host_err  = host_err_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_gpu_host_bridge.sv
// Directed bench for gpu_host_bridge: drivers push expected acks and bus cycles into
// queues, and independent monitors pop and compare when host_ack or ioreq rises.
module tb_gpu_host_bridge;

  logic       sys_clk = 1'b0;
  logic       resetl  = 1'b0;
  logic       tick    = 1'b0;
  logic       big_io  = 1'b0;
  logic [2:0] dbg_state;

  gpu_host_bridge_if bif ();

  gpu_host_bridge dut (
    .sys_clk   (sys_clk),
    .resetl    (resetl),
    .tick      (tick),
    .big_io    (big_io),
    .bus       (bif.slave),
    .dbg_state (dbg_state)
  );

  // Clock / tick generation: tick is high on every third sys_clk.
  initial forever #5 sys_clk = ~sys_clk;

  initial begin
    int cyc;
    cyc = 0;
    forever begin
      @(negedge sys_clk);
      cyc++;
      tick = (cyc % 3 == 0);
    end
  end

  // Scoreboard
  int n_cmp = 0;
  int n_err = 0;
  logic [17:0] exp_ack_q[$];   // {check_dout, err, dout}
  logic [46:0] exp_bus_q[$];   // {check_data, iowr, cpuaddr, cpudata}

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_ack(input logic chk_dout, input logic err, input logic [15:0] dout);
    exp_ack_q.push_back({chk_dout, err, dout});
  endtask

  task automatic push_bus(input logic chk_data, input logic wr, input logic [12:0] addr,
                          input logic [31:0] data);
    exp_bus_q.push_back({chk_data, wr, addr, data});
  endtask

  // Ack monitor
  logic ack_prev = 1'b0;
  always @(negedge sys_clk) begin
    logic [17:0] e;
    if (bif.host_ack && !ack_prev) begin
      if (exp_ack_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_ack: got host_ack=1 expected none at %0t", $time);
      end else begin
        e = exp_ack_q.pop_front();
        chk("ack_err", {63'd0, bif.host_err}, {63'd0, e[16]});
        if (e[17]) chk("ack_dout", {48'd0, bif.host_dout}, {48'd0, e[15:0]});
      end
    end
    ack_prev = bif.host_ack;
  end

  // Bus monitor: checks the qualifiers on ioreq rise and that ioreq spans one tick (3 clocks).
  logic ioreq_prev = 1'b0;
  int   ioreq_width = 0;
  always @(negedge sys_clk) begin
    logic [46:0] e;
    if (bif.ioreq && !ioreq_prev) begin
      ioreq_width = 0;
      if (exp_bus_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_ioreq: got ioreq=1 expected none at %0t", $time);
      end else begin
        e = exp_bus_q.pop_front();
        chk("bus_iowr", {63'd0, bif.iowr}, {63'd0, e[45]});
        chk("bus_cpuaddr", {51'd0, bif.cpuaddr}, {51'd0, e[44:32]});
        if (e[46]) chk("bus_cpudata", {32'd0, bif.cpudata}, {32'd0, e[31:0]});
      end
    end
    if (bif.ioreq) ioreq_width++;
    if (!bif.ioreq && ioreq_prev) chk("ioreq_width", 64'(ioreq_width), 64'd3);
    ioreq_prev = bif.ioreq;
  end

  // Driver tasks
  task automatic tick_edge();
    do @(posedge sys_clk); while (!tick);
    #1;
  endtask

  task automatic do_txn(input logic wr, input logic [13:0] addr, input logic [15:0] din,
                        input int exp_lat, input int drop_at);
    int  lat;
    logic got;
    bif.host_wr   = wr;
    bif.host_addr = addr;
    bif.host_din  = din;
    bif.host_req  = 1'b1;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      tick_edge();
      lat++;
      if (drop_at == lat) bif.host_req = 1'b0;
      if (bif.host_ack) got = 1'b1;
    end
    chk("ack_latency", 64'(lat), 64'(exp_lat));
    if (bif.host_req) begin
      tick_edge();
      chk("ack_hold", {63'd0, bif.host_ack}, 64'd1);
      bif.host_req = 1'b0;
    end
    tick_edge();
    chk("ack_clear", {62'd0, bif.host_ack, bif.host_err}, 64'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ioreq"}, {63'd0, bif.ioreq}, 64'd0);
    chk({tag, "_iowr"}, {63'd0, bif.iowr}, 64'd0);
    chk({tag, "_cpuaddr"}, {51'd0, bif.cpuaddr}, 64'd0);
    chk({tag, "_cpudata"}, {32'd0, bif.cpudata}, 64'd0);
    chk({tag, "_host_dout"}, {48'd0, bif.host_dout}, 64'd0);
    chk({tag, "_host_ack"}, {63'd0, bif.host_ack}, 64'd0);
    chk({tag, "_host_err"}, {63'd0, bif.host_err}, 64'd0);
    chk({tag, "_state"}, {61'd0, dbg_state}, 64'd0);
  endtask

  initial begin
    bif.host_req  = 1'b0;
    bif.host_wr   = 1'b0;
    bif.host_addr = 14'd0;
    bif.host_din  = 16'd0;
    bif.ioserv    = 1'b1;
    bif.mem_data  = 32'hCAFE_BABE;
    resetl        = 1'b0;
    repeat (4) @(posedge sys_clk);
    #1;
    chk_all_zero("reset");
    resetl = 1'b1;
    tick_edge();

    // Write pair, big_io=1: merged long word goes out in one bus cycle.
    big_io = 1'b1;
    push_ack(1'b0, 1'b0, 16'h0);
    do_txn(1'b1, 14'h1000, 16'h1234, 1, 0);
    push_bus(1'b1, 1'b1, 13'h0800, 32'h1234_5678);
    push_ack(1'b0, 1'b0, 16'h0);
    do_txn(1'b1, 14'h1001, 16'h5678, 3, 0);

    // Same sequence, big_io=0.
    big_io = 1'b0;
    push_ack(1'b0, 1'b0, 16'h0);
    do_txn(1'b1, 14'h1000, 16'h1234, 1, 0);
    push_bus(1'b1, 1'b1, 13'h0800, 32'h5678_1234);
    push_ack(1'b0, 1'b0, 16'h0);
    do_txn(1'b1, 14'h1001, 16'h5678, 3, 0);

    // Second-half write with nothing pending: other half is zero.
    big_io = 1'b1;
    push_bus(1'b1, 1'b1, 13'h0101, 32'h0000_AAAA);
    push_ack(1'b0, 1'b0, 16'h0);
    do_txn(1'b1, 14'h0203, 16'hAAAA, 3, 0);

    // Reads of 0xCAFEBABE.
    push_bus(1'b0, 1'b0, 13'h0800, 32'h0);
    push_ack(1'b1, 1'b0, 16'hCAFE);
    do_txn(1'b0, 14'h1000, 16'h0, 4, 0);
`ifdef GPU_HOST_RDLATCH_EN
    push_ack(1'b1, 1'b0, 16'hBABE);
    do_txn(1'b0, 14'h1001, 16'h0, 1, 0);
`else
    push_bus(1'b0, 1'b0, 13'h0800, 32'h0);
    push_ack(1'b1, 1'b0, 16'hBABE);
    do_txn(1'b0, 14'h1001, 16'h0, 4, 0);
`endif
    big_io = 1'b0;
    push_bus(1'b0, 1'b0, 13'h0800, 32'h0);
    push_ack(1'b1, 1'b0, 16'hBABE);
    do_txn(1'b0, 14'h1000, 16'h0, 4, 0);

    // A write to the latched address forces the next second-half read onto the bus.
    big_io = 1'b1;
    push_ack(1'b0, 1'b0, 16'h0);
    do_txn(1'b1, 14'h1000, 16'hABCD, 1, 0);
    bif.mem_data = 32'h1111_2222;
    push_bus(1'b0, 1'b0, 13'h0800, 32'h0);
    push_ack(1'b1, 1'b0, 16'h2222);
    do_txn(1'b0, 14'h1001, 16'h0, 4, 0);

    // Grant timeout, then a normal read.
    bif.ioserv = 1'b0;
    push_bus(1'b0, 1'b0, 13'h0020, 32'h0);
    push_ack(1'b1, 1'b1, 16'h0000);
    do_txn(1'b0, 14'h0040, 16'h0, 17, 0);
    bif.ioserv   = 1'b1;
    bif.mem_data = 32'h0BAD_0F00;
    push_bus(1'b0, 1'b0, 13'h0021, 32'h0);
    push_ack(1'b1, 1'b0, 16'h0BAD);
    do_txn(1'b0, 14'h0042, 16'h0, 4, 0);

    // Reset while waiting for a grant in SERV.
    push_ack(1'b0, 1'b0, 16'h0);
    do_txn(1'b1, 14'h0100, 16'h9999, 1, 0);
    bif.ioserv = 1'b0;
    push_bus(1'b1, 1'b1, 13'h0080, 32'h9999_7777);
    bif.host_wr   = 1'b1;
    bif.host_addr = 14'h0101;
    bif.host_din  = 16'h7777;
    bif.host_req  = 1'b1;
    repeat (3) tick_edge();
    resetl = 1'b0;
    @(posedge sys_clk);
    #1;
    chk_all_zero("serv_reset");
    bif.host_req = 1'b0;
    resetl       = 1'b1;
    bif.ioserv   = 1'b1;
    repeat (3) tick_edge();
    chk("post_reset_no_ack", {63'd0, bif.host_ack}, 64'd0);
    push_bus(1'b1, 1'b1, 13'h0000, 32'h0000_4444);
    push_ack(1'b0, 1'b0, 16'h0);
    do_txn(1'b1, 14'h0001, 16'h4444, 3, 0);

    // host_req dropped during ISSUE: cycle still completes, ack leaves on the first ACK tick.
    push_ack(1'b0, 1'b0, 16'h0);
    do_txn(1'b1, 14'h2000, 16'h1357, 1, 0);
    push_bus(1'b1, 1'b1, 13'h1000, 32'h1357_2468);
    push_ack(1'b0, 1'b0, 16'h0);
    do_txn(1'b1, 14'h2001, 16'h2468, 3, 1);

    repeat (6) @(posedge sys_clk);
    chk("ack_q_drained", 64'(exp_ack_q.size()), 64'd0);
    chk("bus_q_drained", 64'(exp_bus_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gpu_host_bridge.md
GPU_HOST_BRIDGE -- requirements
Module: gpu_host_bridge

Interface
REQ-001 sys_clk  in  1  system clock; all state updates on its rising edge.
REQ-002 resetl  in  1  reset, synchronous, active-low.
REQ-003 tick  in  1  GPU clock-edge strobe, one sys_clk wide; state advances only when tick=1.
REQ-004 host_req  in  1  host transaction request, four-phase level.
REQ-005 host_wr  in  1  1=write, 0=read; stable while host_req=1.
REQ-006 host_addr  in  14  halfword address [14:1] within local GPU space.
REQ-007 host_din  in  16  host write data.
REQ-008 big_io  in  1  1: halfword addr[1]=0 maps to bits 31:16; 0: maps to bits 15:0.
REQ-009 ioserv  in  1  arbiter I/O grant.
REQ-010 mem_data  in  32  registered bus read data.
REQ-011 ioreq  out  1  bus I/O request, one tick wide.
REQ-012 iowr  out  1  bus write qualifier.
REQ-013 cpuaddr  out  13  long-word address [14:2].
REQ-014 cpudata  out  32  assembled write data.
REQ-015 host_dout  out  16  read data to host.
REQ-016 host_ack  out  1  transaction complete.
REQ-017 host_err  out  1  grant timeout; valid while host_ack=1.

Function
REQ-018 States SHALL be IDLE, ISSUE, SERV, CAPT and ACK; none advances without tick.
REQ-019 IDLE, host_req=1, host_wr=1, addr[1]=0: SHALL latch host_din into the pending half of the write register, set wpend, and go to ACK without a bus cycle.
REQ-020 IDLE, host_req=1, host_wr=1, addr[1]=1: SHALL merge host_din with the pending half per big_io into cpudata, load cpuaddr=addr[14:2], set iowr=1 and ioreq=1, clear wpend, and go to ISSUE.
REQ-021 An addr[1]=1 write with wpend=0 SHALL use zero for the other half.
REQ-022 IDLE, host_req=1, read without a latch hit: SHALL set ioreq=1, iowr=0, load cpuaddr, and go to ISSUE.
REQ-023 ISSUE: ioreq SHALL drop on the next tick, giving exactly one tick high, then go to SERV.
REQ-024 SERV, ioserv=1: write SHALL go to ACK, read SHALL go to CAPT.
REQ-025 SERV, ioserv=0: SHALL increment a 4-bit timeout counter.
REQ-026 SERV timeout: on the counter's 15th tick SHALL set host_err=1, force host_dout=0, and go to ACK.
REQ-027 CAPT: SHALL capture mem_data into the read buffer, drive host_dout with the selected half per big_io and addr[1], and go to ACK.
REQ-028 Write latency SHALL be 3 ticks and read latency 4 ticks from the IDLE sample to host_ack high, with ioserv granted on the first SERV tick.
REQ-029 ACK: host_ack SHALL stay 1 until host_req=0 is sampled on a tick, then clear host_ack and host_err and return to IDLE.
REQ-030 host_req dropping before ACK SHALL NOT abort the bus cycle; ACK is entered and left on the first tick.
REQ-031 iowr and cpuaddr SHALL be held from ISSUE through SERV; cpudata SHALL change only in IDLE.
REQ-032 big_io SHALL be sampled per transaction in IDLE.

Reset
REQ-033 resetl=0 SHALL force IDLE, ioreq=0, iowr=0, cpuaddr=0, cpudata=0, host_dout=0, host_ack=0, host_err=0, wpend=0, rvalid=0 and timeout counter=0 on the next sys_clk, regardless of tick or state.
REQ-034 Reset during ISSUE or SERV SHALL drop ioreq without completing or acking.

Configuration
REQ-035 Macro GPU_HOST_RDLATCH_EN defined: an addr[1]=0 read SHALL set rvalid and record addr[14:2].
REQ-036 With the macro defined, an addr[1]=1 read to the recorded address with rvalid=1 SHALL return the buffered other half via ACK in 1 tick with no ioreq.
REQ-037 With the macro defined, any write to the recorded address or any error SHALL clear rvalid.
REQ-038 Macro undefined: every read SHALL perform a bus cycle, and rvalid SHALL be constant 0.

Verification
REQ-039 big_io=1: write 0x1234 @addr 0x1000, then 0x5678 @0x1001 -> one ioreq, cpuaddr=0x0800, cpudata=0x12345678, iowr=1, ack 3 ticks after second request.
REQ-040 big_io=0, same sequence -> cpudata=0x56781234.
REQ-041 Read @0x1000, mem_data=0xCAFEBABE, big_io=1 -> host_dout=0xCAFE at 4 ticks; with macro, read @0x1001 -> 0xBABE, no ioreq, 1-tick ack.
REQ-042 ioserv held 0 -> host_err=1, host_dout=0, ack after 15 SERV ticks; next transaction completes normally.
REQ-043 resetl=0 in SERV -> all outputs 0 next sys_clk, no ack, wpend cleared.
REQ-044 host_req dropped in ISSUE -> exactly one ioreq, write still committed, no lingering host_ack.
